pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Drives write-enables and bubble/flush controls of PC, IF/ID, ID/EX and EX/MEM.
- Handles load-use and RAW stalls, taken-branch squash (branch resolves in MEM) and jump squash in ID.
- Sequences a multi-cycle multiply that occupies EX, and keeps saturating performance counters.

Parameters:
MUL_CYCLES, 4, cycles a mul occupies EX; must be ≥2; value 1 disables mul sequencing (ID_EX_IsMul ignored)
CNT_W, 16, width of the stall/flush performance counters

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset (0 = reset)
ID_Rs, ID_Rt  in  5 each  source register fields of the instruction in ID
ID_UsesRs, ID_UsesRt  in  1 each  ID instruction actually reads rs / rt
ID_Jump  in  1  ID instruction is j/jal
ID_EX_MemRead  in  1  ID/EX holds a load
ID_EX_RegWrite  in  1  ID/EX instruction writes a register
ID_EX_WriteReg  in  5  ID/EX destination after RegDst mux
ID_EX_IsMul  in  1  ID/EX holds a multi-cycle mul
EX_MEM_RegWrite, EX_MEM_WriteReg  in  1, 5  EX/MEM destination info
MEM_WB_RegWrite, MEM_WB_WriteReg  in  1, 5  MEM/WB destination info
PCSrc  in  1  taken branch, from the EX/MEM Branch & Zero AND
PCWrite  out  1  PC load enable
IF_ID_Write  out  1  IF/ID load enable
IF_ID_Flush  out  1  load NOP into IF/ID
ID_EX_Write  out  1  ID/EX load enable (0 = hold)
ID_EX_Bubble  out  1  load zeroed controls into ID/EX
EX_MEM_Bubble  out  1  load zeroed controls into EX/MEM
MulBusy  out  1  state == MUL_WAIT
StallCount  out  CNT_W  saturating count of cycles with PCWrite=0
FlushCount  out  CNT_W  saturating count of PCSrc flushes

Behaviour:
- While Reset=0: state=RUN, mul counter=0, both counters=0. Outputs forced to PCWrite=IF_ID_Write=ID_EX_Write=0, IF_ID_Flush=ID_EX_Bubble=EX_MEM_Bubble=1, MulBusy=0. The pipeline drains to NOPs. Reset mid-mul aborts the mul.
- Outputs are combinational from state plus inputs. Zero latency: a hazard seen in cycle T takes effect at the T edge.
- Default (no event): PCWrite=IF_ID_Write=ID_EX_Write=1, all flush/bubble=0.
- Priority, highest first: PCSrc > mul sequencing > data stall > ID_Jump.
- PCSrc=1, any state:
  - Outputs: PCWrite=1, IF_ID_Flush=ID_EX_Bubble=EX_MEM_Bubble=1, ID_EX_Write=1.
  - Next state is RUN; an in-progress mul is squashed.
  - FlushCount increments.
- Data hazard, only when the source is used and the matched register ≠ $0:
  - Load-use: ID_EX_MemRead & ID_EX_WriteReg matches ID_Rs or ID_Rt.
  - Action: PCWrite=IF_ID_Write=0, ID_EX_Bubble=1, for one cycle per detected cycle.
- ID_Jump (no higher event): IF_ID_Flush=1, PCWrite=1.
- State RUN with ID_EX_IsMul=1 and MUL_CYCLES≥2:
  - Hold cycle outputs: PCWrite=IF_ID_Write=ID_EX_Write=0, EX_MEM_Bubble=1.
  - mulcnt ← MUL_CYCLES-2; next state MUL_WAIT.
- State MUL_WAIT:
  - mulcnt≠0: hold outputs as above, mulcnt decrements.
  - mulcnt==0: release cycle with default outputs (mul advances to EX/MEM); next state RUN.
  - The mul therefore occupies EX for exactly MUL_CYCLES cycles.
  - ID_EX_IsMul is not re-sampled in MUL_WAIT.
- Counters: StallCount +1 in every post-reset cycle where PCWrite=0; FlushCount +1 per PCSrc cycle. Both hold at all-ones and never wrap.

Optional Feature:
FORWARDING_EN
- Defined: a forwarding unit exists, so only the load-use stall applies. EX_MEM_*, MEM_WB_* and non-load ID/EX RAW conditions are ignored.
- Undefined: stall (same outputs as load-use) whenever a used ID source ≠0 matches the destination of any of ID/EX, EX/MEM or MEM/WB with its RegWrite=1.

Test Plan:
- Reset=0 for 3 cycles, mid-mul → PCWrite=0, all bubbles=1, counters=0. Release → PCWrite=1, MulBusy=0.
- lw $8 in ID/EX, ID add uses rs=$8 → exactly 1 cycle PCWrite=0, ID_EX_Bubble=1; StallCount=1. Same with dest $0 → no stall.
- ID_EX_IsMul=1 with MUL_CYCLES=4 → 3 hold cycles (EX_MEM_Bubble=1, MulBusy high for cycles 2-3), release in cycle 4; StallCount=3.
- PCSrc=1 during MUL_WAIT with mulcnt=1 → same cycle IF_ID_Flush=ID_EX_Bubble=EX_MEM_Bubble=1, PCWrite=1, next state RUN; FlushCount=1.
- FORWARDING_EN undefined: EX_MEM_WriteReg=$9, RegWrite=1, ID rt=$9 used → stall. With the macro defined, the same stimulus → no stall.
- Force 65536 stall cycles → StallCount holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the 5-stage pipeline datapath and its stall/flush sequencer.
// slave: the sequencer; master: the datapath that supplies hazard info and consumes the controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_Jump;
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWrite;
  logic [4:0]       ID_EX_WriteReg;
  logic             ID_EX_IsMul;
  logic             EX_MEM_RegWrite;
  logic [4:0]       EX_MEM_WriteReg;
  logic             MEM_WB_RegWrite;
  logic [4:0]       MEM_WB_WriteReg;
  logic             PCSrc;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Bubble;
  logic             EX_MEM_Bubble;
  logic             MulBusy;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Jump,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_WriteReg, ID_EX_IsMul,
           EX_MEM_RegWrite, EX_MEM_WriteReg, MEM_WB_RegWrite, MEM_WB_WriteReg, PCSrc,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble,
           MulBusy, StallCount, FlushCount
  );

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Jump,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_WriteReg, ID_EX_IsMul,
           EX_MEM_RegWrite, EX_MEM_WriteReg, MEM_WB_RegWrite, MEM_WB_WriteReg, PCSrc,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble,
           MulBusy, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use/RAW stalls, branch/jump squash,
// multi-cycle mul hold and saturating perf counters. Define FORWARDING_EN to keep only the load-use stall.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input logic                 Clk,
  input logic                 Reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam int MCW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam bit MUL_EN = (MUL_CYCLES >= 2);
  localparam logic [MCW-1:0] MUL_LOAD = MCW'((MUL_CYCLES >= 2) ? (MUL_CYCLES - 2) : 0);

  state_t           state, nextState;
  logic [MCW-1:0]   mulCnt, mulCntNext;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic             pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble;
  logic             loadUse, rawHit, dataStall;

  function automatic logic srcHit(logic [4:0] src, logic used, logic [4:0] dst);
    return used && (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [CNT_W-1:0] satInc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign loadUse = hz.ID_EX_MemRead &&
                   (srcHit(hz.ID_Rs, hz.ID_UsesRs, hz.ID_EX_WriteReg) ||
                    srcHit(hz.ID_Rt, hz.ID_UsesRt, hz.ID_EX_WriteReg));

`ifdef FORWARDING_EN
  // Forwarding covers every non-load RAW case, so those inputs are deliberately ignored.
  logic unusedFwd;
  assign unusedFwd = ^{hz.ID_EX_RegWrite, hz.EX_MEM_RegWrite, hz.EX_MEM_WriteReg,
                       hz.MEM_WB_RegWrite, hz.MEM_WB_WriteReg};
  assign rawHit = 1'b0;
`else
  assign rawHit =
    (hz.ID_EX_RegWrite  && (srcHit(hz.ID_Rs, hz.ID_UsesRs, hz.ID_EX_WriteReg)  ||
                            srcHit(hz.ID_Rt, hz.ID_UsesRt, hz.ID_EX_WriteReg)))  ||
    (hz.EX_MEM_RegWrite && (srcHit(hz.ID_Rs, hz.ID_UsesRs, hz.EX_MEM_WriteReg) ||
                            srcHit(hz.ID_Rt, hz.ID_UsesRt, hz.EX_MEM_WriteReg))) ||
    (hz.MEM_WB_RegWrite && (srcHit(hz.ID_Rs, hz.ID_UsesRs, hz.MEM_WB_WriteReg) ||
                            srcHit(hz.ID_Rt, hz.ID_UsesRt, hz.MEM_WB_WriteReg)));
`endif

  assign dataStall = loadUse || rawHit;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= RUN;
      mulCnt   <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      state  <= nextState;
      mulCnt <= mulCntNext;
      if (!pcWrite)
        stallCnt <= satInc(stallCnt);
      if (hz.PCSrc)
        flushCnt <= satInc(flushCnt);
    end
  end

  // Priority chain: reset drain, branch squash, mul sequencing, data stall, jump squash.
  always_comb begin
    nextState   = state;
    mulCntNext  = mulCnt;
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    idExWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    exMemBubble = 1'b0;
    if (!Reset) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      ifIdFlush   = 1'b1;
      idExBubble  = 1'b1;
      exMemBubble = 1'b1;
      nextState   = RUN;
      mulCntNext  = '0;
    end else if (hz.PCSrc) begin
      ifIdFlush   = 1'b1;
      idExBubble  = 1'b1;
      exMemBubble = 1'b1;
      nextState   = RUN;
      mulCntNext  = '0;
    end else if (MUL_EN && (state == RUN) && hz.ID_EX_IsMul) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemBubble = 1'b1;
      nextState   = MUL_WAIT;
      mulCntNext  = MUL_LOAD;
    end else if (state == MUL_WAIT) begin
      if (mulCnt != '0) begin
        pcWrite     = 1'b0;
        ifIdWrite   = 1'b0;
        idExWrite   = 1'b0;
        exMemBubble = 1'b1;
        mulCntNext  = mulCnt - MCW'(1);
      end else begin
        nextState = RUN;
      end
    end else if (dataStall) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
    end else if (hz.ID_Jump) begin
      ifIdFlush = 1'b1;
    end
  end

  assign hz.PCWrite       = pcWrite;
  assign hz.IF_ID_Write   = ifIdWrite;
  assign hz.IF_ID_Flush   = ifIdFlush;
  assign hz.ID_EX_Write   = idExWrite;
  assign hz.ID_EX_Bubble  = idExBubble;
  assign hz.EX_MEM_Bubble = exMemBubble;
  assign hz.MulBusy       = Reset && (state == MUL_WAIT);
  assign hz.StallCount    = stallCnt;
  assign hz.FlushCount    = flushCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus hand sequences for mul, reset,
// branch-during-mul and counter saturation, checked through an expected-result queue.
module tb_pipeline_hazard_ctrl;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, MulBusy}
  typedef logic [6:0] outs_t;

  localparam outs_t RUNO  = 7'b1101000;
  localparam outs_t RELB  = 7'b1101001;
  localparam outs_t STALL = 7'b0001100;
  localparam outs_t FLUSH = 7'b1111110;
  localparam outs_t FLUSB = 7'b1111111;
  localparam outs_t JUMP  = 7'b1111000;
  localparam outs_t HOLD  = 7'b0000010;
  localparam outs_t HOLDB = 7'b0000011;
  localparam outs_t RSTO  = 7'b0010110;
`ifdef FORWARDING_EN
  localparam outs_t RAWE  = RUNO;
`else
  localparam outs_t RAWE  = STALL;
`endif

  typedef struct {
    string      nm;
    logic [4:0] rs, rt;
    logic       uRs, uRt, jmp, mr, irw;
    logic [4:0] iwr;
    logic       erw;
    logic [4:0] ewr;
    logic       mrw;
    logic [4:0] mwr;
    logic       pcs;
    outs_t      e;
  } vec_t;

  typedef struct {
    string       nm;
    outs_t       o;
    logic [15:0] s, f;
  } sb_t;

  logic Clk;
  logic Reset;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] stallM = 16'd0;
  logic [15:0] flushM = 16'd0;
  logic [15:0] s0;
  vec_t vecs[$];
  sb_t  expQ[$];

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hif();

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (hif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sat(logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    hif.ID_Rs = 5'd0; hif.ID_Rt = 5'd0; hif.ID_UsesRs = 1'b0; hif.ID_UsesRt = 1'b0;
    hif.ID_Jump = 1'b0; hif.ID_EX_MemRead = 1'b0; hif.ID_EX_RegWrite = 1'b0;
    hif.ID_EX_WriteReg = 5'd0; hif.ID_EX_IsMul = 1'b0;
    hif.EX_MEM_RegWrite = 1'b0; hif.EX_MEM_WriteReg = 5'd0;
    hif.MEM_WB_RegWrite = 1'b0; hif.MEM_WB_WriteReg = 5'd0; hif.PCSrc = 1'b0;
  endtask

  // One clock cycle: push expectation, compare at the falling edge, advance the counter model.
  task automatic cycle(outs_t e, string nm);
    sb_t s, g;
    outs_t got;
    if (!Reset) begin stallM = 16'd0; flushM = 16'd0; end
    s.nm = nm; s.o = e; s.s = stallM; s.f = flushM;
    expQ.push_back(s);
    @(negedge Clk);
    g = expQ.pop_front();
    got = {hif.PCWrite, hif.IF_ID_Write, hif.IF_ID_Flush, hif.ID_EX_Write,
           hif.ID_EX_Bubble, hif.EX_MEM_Bubble, hif.MulBusy};
    chk({g.nm, ".ctl"},   32'(got), 32'(g.o));
    chk({g.nm, ".stall"}, 32'(hif.StallCount), 32'(g.s));
    chk({g.nm, ".flush"}, 32'(hif.FlushCount), 32'(g.f));
    if (Reset) begin
      if (!e[6]) stallM = sat(stallM);
      if (hif.PCSrc) flushM = sat(flushM);
    end
    @(posedge Clk); #1;
  endtask

  task automatic applyVec(vec_t v);
    hif.ID_Rs = v.rs; hif.ID_Rt = v.rt; hif.ID_UsesRs = v.uRs; hif.ID_UsesRt = v.uRt;
    hif.ID_Jump = v.jmp; hif.ID_EX_MemRead = v.mr; hif.ID_EX_RegWrite = v.irw;
    hif.ID_EX_WriteReg = v.iwr; hif.ID_EX_IsMul = 1'b0;
    hif.EX_MEM_RegWrite = v.erw; hif.EX_MEM_WriteReg = v.ewr;
    hif.MEM_WB_RegWrite = v.mrw; hif.MEM_WB_WriteReg = v.mwr; hif.PCSrc = v.pcs;
    cycle(v.e, v.nm);
  endtask

  initial begin
    //           nm         rs     rt     uRs   uRt   jmp   mr    irw   iwr    erw   ewr    mrw   mwr    pcs   exp
    vecs.push_back('{"idle",   5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, RUNO});
    vecs.push_back('{"ldRs",   5'd8,  5'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, STALL});
    vecs.push_back('{"ldRt",   5'd3,  5'd8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, STALL});
    vecs.push_back('{"ldZero", 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, RUNO});
    vecs.push_back('{"ldUnused",5'd3, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, RUNO});
    vecs.push_back('{"rawExMem",5'd1, 5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd9,  1'b0, 5'd0,  1'b0, RAWE});
    vecs.push_back('{"rawMemWb",5'd3, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd3,  1'b0, RAWE});
    vecs.push_back('{"rawIdEx", 5'd5, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, RAWE});
    vecs.push_back('{"noRegWr", 5'd1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9,  1'b0, 5'd9,  1'b0, 5'd9,  1'b0, RUNO});
    vecs.push_back('{"jump",    5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, JUMP});
    vecs.push_back('{"jmpLd",   5'd7, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, STALL});
    vecs.push_back('{"brAll",   5'd7, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, FLUSH});
    vecs.push_back('{"branch",  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, FLUSH});

    // Power-on reset
    idle();
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cycle(RSTO, "por");
    Reset = 1'b1;
    cycle(RUNO, "porRel");

    // Single-cycle vectors
    for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i]);
    idle();

    // Mul occupies EX for four cycles: three holds then a release
    s0 = hif.StallCount;
    hif.ID_EX_IsMul = 1'b1;
    cycle(HOLD,  "mul1");
    cycle(HOLDB, "mul2");
    cycle(HOLDB, "mul3");
    cycle(RELB,  "mulRel");
    hif.ID_EX_IsMul = 1'b0;
    cycle(RUNO,  "mulDone");
    chk("mulStallDelta", 32'(hif.StallCount - s0), 32'd3);

    // Reset in the middle of a mul aborts it
    hif.ID_EX_IsMul = 1'b1;
    cycle(HOLD,  "rmul1");
    cycle(HOLDB, "rmul2");
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(RSTO, "rstMul");
    Reset = 1'b1;
    hif.ID_EX_IsMul = 1'b0;
    cycle(RUNO, "rstRel");

    // Taken branch while the mul counter is 1 squashes it
    hif.ID_EX_IsMul = 1'b1;
    cycle(HOLD,  "bmul1");
    cycle(HOLDB, "bmul2");
    hif.PCSrc = 1'b1;
    cycle(FLUSB, "bmulBr");
    hif.PCSrc = 1'b0;
    hif.ID_EX_IsMul = 1'b0;
    cycle(RUNO,  "bmulRun");
    chk("brFlushCount", 32'(hif.FlushCount), 32'd1);
    chk("brStallCount", 32'(hif.StallCount), 32'd2);

    // Long load-use stall saturates StallCount
    hif.ID_Rs = 5'd8; hif.ID_UsesRs = 1'b1;
    hif.ID_EX_MemRead = 1'b1; hif.ID_EX_WriteReg = 5'd8;
    for (int i = 0; i < 65540; i++) @(posedge Clk);
    #1;
    chk("satStall", 32'(hif.StallCount), 32'h0000_FFFF);
    chk("satPCWrite", 32'(hif.PCWrite), 32'd0);
    stallM = 16'hFFFF;
    cycle(STALL, "satHold");
    idle();
    cycle(RUNO, "satIdle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
